// File: rtl/wrr_defs.sv
// Shared definitions for the weighted round-robin VC scheduler:
// FSM state encoding, default widths and a constant-foldable clog2.
package wrr_defs;

  typedef enum logic {
    SELECT = 1'b0,
    SERVE  = 1'b1
  } state_e;

  localparam int DEF_NUM_VC   = 4;
  localparam int DEF_DATA_W   = 4;
  localparam int DEF_WEIGHT_W = 3;

  // Smallest n with 2**n >= value; used to size the channel pointer.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_next_eligible.sv
// Cyclic first-eligible search: rotate the eligible vector so that 'start'
// lands on bit 0, priority-encode the lowest set bit, then rotate the
// resulting offset back into an absolute channel index (mod NUM_VC).
module rr_next_eligible
  import wrr_defs::*;
#(
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int SEL_W  = clog2(DEF_NUM_VC)
) (
  input  logic [NUM_VC-1:0] eligible,
  input  logic [SEL_W-1:0]  start,
  output logic              found,
  output logic [SEL_W-1:0]  index
);

  logic [NUM_VC-1:0] rotated;
  logic [SEL_W-1:0]  offset;
  logic [SEL_W:0]    sum;

  // Rotate, find the lowest eligible offset, and map it back to a channel.
  always_comb begin
    rotated = (eligible >> start) | (eligible << (NUM_VC - int'(start)));
    found   = 1'b0;
    offset  = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found  = 1'b1;
        offset = SEL_W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (SEL_W + 1)'(NUM_VC)) begin
      sum = sum - (SEL_W + 1)'(NUM_VC);
    end
    index = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler draining NUM_VC show-ahead FIFOs into one
// stream. SELECT picks the next eligible channel and loads its weight as
// credit; SERVE pops that channel until credit runs out or it empties.
module wrr_vc_scheduler
  import wrr_defs::*;
#(
  parameter  int NUM_VC   = DEF_NUM_VC,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int WEIGHT_W = DEF_WEIGHT_W,
  localparam int SEL_W    = clog2(NUM_VC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enb,
  input  logic [NUM_VC*DATA_W-1:0]   vc_data,
  input  logic [NUM_VC-1:0]          vc_empty,
  input  logic [NUM_VC*WEIGHT_W-1:0] vc_weight,
  input  logic                       dest_full,
  output logic [NUM_VC-1:0]          vc_pop,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  output logic [SEL_W-1:0]           arbiter
);

  state_e              state;
  logic [WEIGHT_W-1:0] credit;
  logic [SEL_W-1:0]    start;
  logic [NUM_VC-1:0]   eligible;
  logic                found;
  logic [SEL_W-1:0]    next_idx;
  logic                grant;
  logic [SEL_W-1:0]    after_arb;

  // A channel can be chosen only if it has data and a non-zero weight.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      eligible[i] = !vc_empty[i] && (vc_weight[i*WEIGHT_W +: WEIGHT_W] != '0);
    end
  end

  rr_next_eligible #(
    .NUM_VC (NUM_VC),
    .SEL_W  (SEL_W)
  ) u_next (
    .eligible (eligible),
    .start    (start),
    .found    (found),
    .index    (next_idx)
  );

  assign grant     = (state == SERVE) && enb && !dest_full && !vc_empty[arbiter];
  assign after_arb = (arbiter == SEL_W'(NUM_VC - 1)) ? '0 : arbiter + 1'b1;

  // Pop the served channel in the same cycle as the grant.
  always_comb begin
    vc_pop = '0;
    if (grant) begin
      vc_pop[arbiter] = 1'b1;
    end
  end

  // Scheduler FSM with credit counter, search start pointer and output regs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SELECT;
      arbiter   <= '0;
      credit    <= '0;
      start     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        SELECT: begin
          if (enb && found) begin
            arbiter <= next_idx;
            credit  <= vc_weight[next_idx*WEIGHT_W +: WEIGHT_W];
            state   <= SERVE;
          end
        end
        SERVE: begin
          if (grant) begin
            out_data  <= vc_data[arbiter*DATA_W +: DATA_W];
            out_valid <= 1'b1;
            if (credit == WEIGHT_W'(1)) begin
              state <= SELECT;
              start <= after_arb;
            end else begin
              credit <= credit - 1'b1;
            end
          end else if (enb && !dest_full) begin
            state <= SELECT;
            start <= after_arb;
          end
        end
        default: state <= SELECT;
      endcase
    end
  end

endmodule

// File: doc/wrr_vc_scheduler.md
Name: wrr_vc_scheduler

Overview:
- Parametrised weighted round-robin scheduler that drains NUM_VC virtual-channel FIFOs into one output stream.
- Each channel gets up to its programmable weight of consecutive grants per turn. Empty or zero-weight channels are skipped.
- Honours downstream backpressure.
- Sits between the per-VC FIFOs and the egress FIFO. Next generation of the fixed 4-channel, 4-bit weighted round robin.

Parameters:
- NUM_VC, 4, number of virtual channels (2..16).
- DATA_W, 4, data width per channel.
- WEIGHT_W, 3, width of each weight field; max weight 2^WEIGHT_W-1.
- SEL_W, clog2(NUM_VC), derived localparam; width of arbiter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- enb  in  1  scheduler enable.
- vc_data  in  NUM_VC*DATA_W  show-ahead FIFO heads; channel i at [i*DATA_W +: DATA_W].
- vc_empty  in  NUM_VC  FIFO empty flags.
- vc_weight  in  NUM_VC*WEIGHT_W  per-channel weight; 0 = channel disabled.
- dest_full  in  1  downstream almost-full; blocks grants.
- vc_pop  out  NUM_VC  one-hot pop. Combinational from registered state and inputs.
- out_data  out  DATA_W  registered granted word.
- out_valid  out  1  registered; out_data valid this cycle.
- arbiter  out  SEL_W  registered channel pointer.

Behaviour:
- Reset (rst=0, async, any time):
  - state=SELECT, arbiter=0, credit=0, start=0.
  - out_valid=0, out_data=0, vc_pop=0.
  - All effects are immediate, including mid-burst.
- eligible[i] = !vc_empty[i] && vc_weight[i]!=0.
- SELECT state, enb=1:
  - Search cyclically from start (inclusive) for the first eligible channel.
  - If found: arbiter<=it, credit<=its weight, state<=SERVE.
  - If none found: stay in SELECT; arbiter holds.
  - No pop is issued in SELECT, so a channel switch costs exactly one bubble cycle.
- SERVE state:
  - grant = enb && !dest_full && !vc_empty[arbiter].
  - On grant:
    - vc_pop[arbiter]=1 in the same cycle.
    - Next edge: out_data<=vc_data[arbiter], out_valid<=1.
    - If credit==1: state<=SELECT, start<=arbiter+1 (mod NUM_VC). Otherwise credit<=credit-1.
  - enb=1, dest_full=0, vc_empty[arbiter]=1: forfeit remaining credit; state<=SELECT, start<=arbiter+1.
  - dest_full=1 or enb=0: no pop; credit, arbiter and state are frozen.
- out_valid is 1 only in the cycle after a grant, otherwise 0. out_data holds its last value when out_valid=0.
- A single eligible channel re-selects itself: pattern is weight grants, one bubble, repeat.
- Weights are sampled only on load in SELECT. Changing a weight mid-burst does not affect the current credit.
- Wrap-around: start and the search index are computed mod NUM_VC; channel NUM_VC-1 is followed by channel 0.
- Latency: pop to out_valid = 1 cycle.
- Peak throughput per round: sum(weights) words per (sum(weights) + active channels) cycles.

Decomposition:
- Shared package/header wrr_defs:
  - State encodings SELECT=1'b0, SERVE=1'b1.
  - clog2 function.
  - Default widths.
- Sub-module rr_next_eligible (combinational):
  - Inputs: eligible vector and start index.
  - Outputs: found flag and index.
  - Implementation: rotate, priority-encode, rotate back.
- The parent holds the FSM, credit counter, pointer and output registers.

Test Plan:
1. Hold rst=0 with random inputs, then release -> out_valid=0, arbiter=0, vc_pop=0 throughout reset; after release, first pop occurs on the 2nd enabled cycle.
2. Channels all non-empty, weights ch0..3={1,2,3,4}, enb=1, dest_full=0 -> grant sequence 0,1,1,2,2,2,3,3,3,3, with exactly one bubble before each channel's first grant; repeats; out_data matches popped heads in order.
3. Weights {2,0,3,1}, ch2 empty -> sequence 0,0,3,0,0,3; ch1 and ch2 vc_pop never asserted.
4. ch2 weight 3 serving; after its 1st grant, dest_full=1 for 5 cycles -> no pops, arbiter=2, out_valid=0; after deassert, exactly 2 more ch2 grants, then move to ch3.
5. ch3 weight 4 holds 2 words -> 2 grants, then ch3 empties; next cycle SELECT, then the next grant is to ch0 (wrap).
6. rst=0 mid-SERVE on ch1 with credit 2 -> outputs zero asynchronously; after release, service restarts at ch0 with full weight.
